// File: rtl/hazard_forward_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit_if
//   Bundles the ID-stage hazard inputs and the EX-stage forwarding/flush
//   outputs that pass between the pipeline and hazard_forward_unit.
//
//   Parameters:
//     RA_W          register-address width (must match the unit's RA_W)
//
//   Signals (direction as seen by the hazard unit, modport slave):
//     id_rs1/id_rs2       in   source registers of the instruction in ID
//     id_use_rs1/2        in   instruction in ID actually reads rs1/rs2
//     id_rd, id_regwrite  in   destination of the instruction in ID
//     id_memread          in   instruction in ID is a load
//     branch_taken        in   registered branch_taken from Execute
//     forwardA/forwardB   out  EX operand selects (00 reg, 10 MEM, 01 WB)
//     stall               out  load-use stall (combinational)
//     flush               out  squash younger instructions (registered)
//     stall_count         out  saturating stall-cycle count  (HAZARD_STATS_EN)
//     flush_count         out  saturating flush-entry count  (HAZARD_STATS_EN)
//
//   Optional feature macro: HAZARD_STATS_EN
// ---------------------------------------------------------------------------
interface hazard_forward_unit_if #(
  parameter int unsigned RA_W = 3
);
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic [RA_W-1:0] id_rd;
  logic            id_regwrite;
  logic            id_memread;
  logic            branch_taken;
  logic [1:0]      forwardA;
  logic [1:0]      forwardB;
  logic            stall;
  logic            flush;
`ifdef HAZARD_STATS_EN
  logic [15:0]     stall_count;
  logic [15:0]     flush_count;
`endif

`ifdef HAZARD_STATS_EN
  // Pipeline side: presents ID fields, consumes hazard decisions.
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output id_rd, id_regwrite, id_memread, branch_taken,
    input  forwardA, forwardB, stall, flush,
    input  stall_count, flush_count
  );

  // Hazard unit side.
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  id_rd, id_regwrite, id_memread, branch_taken,
    output forwardA, forwardB, stall, flush,
    output stall_count, flush_count
  );
`else
  // Pipeline side: presents ID fields, consumes hazard decisions.
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output id_rd, id_regwrite, id_memread, branch_taken,
    input  forwardA, forwardB, stall, flush
  );

  // Hazard unit side.
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  id_rd, id_regwrite, id_memread, branch_taken,
    output forwardA, forwardB, stall, flush
  );
`endif

endinterface : hazard_forward_unit_if

// File: rtl/hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit
//   Hazard detection and operand forwarding for the EX stage of the 8-bit
//   pipelined core. Keeps a shadow of the destination-register info of the
//   instructions in EX and MEM, compares the instruction in ID against it and
//   registers forwardA/forwardB so they are valid during that instruction's
//   EX cycle. Also raises the load-use stall and the post-branch flush.
//
//   Parameters:
//     RA_W         register-address width (r0 is hard-wired zero)
//     FLUSH_DEPTH  cycles flush is held after a taken branch (1..7)
//
//   Ports:
//     clk    in  rising-edge clock
//     reset  in  asynchronous, active-high reset
//     bus    hazard_forward_unit_if.slave (ID fields in, forward/stall/flush
//            out, plus stall_count/flush_count when HAZARD_STATS_EN is set)
//
//   Optional feature macro: HAZARD_STATS_EN (saturating 16-bit stall/flush
//   event counters). Forwarding, stall and flush behaviour are identical with
//   or without it.
// ---------------------------------------------------------------------------
module hazard_forward_unit #(
  parameter int unsigned RA_W        = 3,
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  hazard_forward_unit_if.slave bus
);

  localparam int unsigned CNT_W = 3;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef enum logic {
    S_RUN,
    S_FLUSH
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_flush;

  // Shadow of the instruction currently in EX.
  logic [RA_W-1:0]   r_ex_rd;
  logic              r_ex_we;
  logic              r_ex_ld;

  // Shadow of the instruction currently in MEM.
  logic [RA_W-1:0]   r_mem_rd;
  logic              r_mem_we;

  logic [1:0]        r_fwd_a;
  logic [1:0]        r_fwd_b;

  logic              w_stall;
  logic              w_bubble;
  logic              w_enter_flush;
  logic              w_hit_rs1;
  logic              w_hit_rs2;
  logic [1:0]        w_fwd_a;
  logic [1:0]        w_fwd_b;

  // -------------------------------------------------------------------------
  // Forward select for one source operand. The EX-stage producer is checked
  // first: it is the younger writer, so its value must win over MEM.
  // -------------------------------------------------------------------------
  function automatic logic [1:0] fwd_sel(
    input logic [RA_W-1:0] src,
    input logic            use_src,
    input logic            ex_we,
    input logic [RA_W-1:0] ex_rd,
    input logic            mem_we,
    input logic [RA_W-1:0] mem_rd
  );
    logic [1:0] sel;
    sel = FWD_REG;
    if (use_src && (src != '0)) begin
      if (ex_we && (ex_rd == src)) begin
        sel = FWD_MEM;
      end else if (mem_we && (mem_rd == src)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

  // -------------------------------------------------------------------------
  // Combinational hazard decisions
  // -------------------------------------------------------------------------
  always_comb begin
    w_hit_rs1 = 1'b0;
    w_hit_rs2 = 1'b0;
    w_stall   = 1'b0;

    w_hit_rs1 = bus.id_use_rs1 && (bus.id_rs1 == r_ex_rd);
    w_hit_rs2 = bus.id_use_rs2 && (bus.id_rs2 == r_ex_rd);

    // Flush dominates: no stall is raised while squashing.
    w_stall = (r_state == S_RUN) && !r_flush &&
              r_ex_ld && r_ex_we && (r_ex_rd != '0) &&
              (w_hit_rs1 || w_hit_rs2);
  end

  always_comb begin
    w_fwd_a = FWD_REG;
    w_fwd_b = FWD_REG;
    w_fwd_a = fwd_sel(bus.id_rs1, bus.id_use_rs1,
                      r_ex_we, r_ex_rd, r_mem_we, r_mem_rd);
    w_fwd_b = fwd_sel(bus.id_rs2, bus.id_use_rs2,
                      r_ex_we, r_ex_rd, r_mem_we, r_mem_rd);
  end

  // A bubble enters EX whenever ID is held (stall) or being squashed (flush).
  assign w_bubble      = w_stall || r_flush;
  assign w_enter_flush = (r_state == S_RUN) && bus.branch_taken;

  // -------------------------------------------------------------------------
  // Shadow pipeline and registered forwarding selects
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_rd  <= '0;
      r_ex_we  <= 1'b0;
      r_ex_ld  <= 1'b0;
      r_mem_rd <= '0;
      r_mem_we <= 1'b0;
      r_fwd_a  <= FWD_REG;
      r_fwd_b  <= FWD_REG;
    end else begin
      r_mem_rd <= r_ex_rd;
      r_mem_we <= r_ex_we;
      if (w_bubble) begin
        r_ex_rd <= bus.id_rd;
        r_ex_we <= 1'b0;
        r_ex_ld <= 1'b0;
        r_fwd_a <= FWD_REG;
        r_fwd_b <= FWD_REG;
      end else begin
        r_ex_rd <= bus.id_rd;
        r_ex_we <= bus.id_regwrite;
        r_ex_ld <= bus.id_memread;
        r_fwd_a <= w_fwd_a;
        r_fwd_b <= w_fwd_b;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Branch flush FSM. flush is registered here; the counter runs from
  // FLUSH_DEPTH-1 down to 0 so flush stays high exactly FLUSH_DEPTH cycles.
  // branch_taken is only sampled in RUN, so a flush cannot be extended.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
      r_flush <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_enter_flush) begin
            r_state <= S_FLUSH;
            r_cnt   <= CNT_W'(FLUSH_DEPTH - 1);
            r_flush <= 1'b1;
          end
        end
        S_FLUSH: begin
          if (r_cnt == '0) begin
            r_state <= S_RUN;
            r_flush <= 1'b0;
          end else begin
            r_cnt   <= r_cnt - CNT_W'(1);
            r_flush <= 1'b1;
          end
        end
        default: begin
          r_state <= S_RUN;
          r_cnt   <= '0;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Optional event counters
  // -------------------------------------------------------------------------
`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_count;
  logic [15:0] r_flush_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_stall && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
      if (w_enter_flush && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end
  end

  assign bus.stall_count = r_stall_count;
  assign bus.flush_count = r_flush_count;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.forwardA = r_fwd_a;
  assign bus.forwardB = r_fwd_b;
  assign bus.stall    = w_stall;
  assign bus.flush    = r_flush;

endmodule : hazard_forward_unit

// File: tb/tb_hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_forward_unit
//   Self-checking bench for hazard_forward_unit (RA_W=3, FLUSH_DEPTH=2).
//   Each row is one ID-stage instruction plus the stall expected while it sits
//   in ID and the forwardA/forwardB/flush expected after the following edge.
// ---------------------------------------------------------------------------
module tb_hazard_forward_unit;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  hazard_forward_unit_if #(.RA_W(3)) bus ();

  hazard_forward_unit #(
    .RA_W        (3),
    .FLUSH_DEPTH (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0] rs1;
    logic       u1;
    logic [2:0] rs2;
    logic       u2;
    logic [2:0] rd;
    logic       rw;
    logic       mr;
    logic       br;
    logic       st;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       fl;
  } row_t;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [5:0]  sb[$];
  logic        obs_stall;

  function automatic row_t mk(
    input logic [2:0] rs1, input logic u1,
    input logic [2:0] rs2, input logic u2,
    input logic [2:0] rd,  input logic rw, input logic mr, input logic br,
    input logic st, input logic [1:0] fa, input logic [1:0] fb, input logic fl
  );
    row_t r;
    r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2;
    r.rd  = rd;  r.rw = rw; r.mr  = mr;  r.br = br;
    r.st  = st;  r.fa = fa; r.fb  = fb;  r.fl = fl;
    return r;
  endfunction

  function automatic row_t nop();
    return mk(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0,
              1'b0, 2'b00, 2'b00, 1'b0);
  endfunction

  // Called one time unit after a rising edge: presents the row in ID, pushes
  // its expectation, samples the combinational stall and advances one cycle.
  task automatic drive(input row_t r);
    bus.id_rs1       = r.rs1;
    bus.id_use_rs1   = r.u1;
    bus.id_rs2       = r.rs2;
    bus.id_use_rs2   = r.u2;
    bus.id_rd        = r.rd;
    bus.id_regwrite  = r.rw;
    bus.id_memread   = r.mr;
    bus.branch_taken = r.br;
    sb.push_back({r.st, r.fa, r.fb, r.fl});
    #1 obs_stall = bus.stall;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    bus.id_rs1 = 3'd0; bus.id_use_rs1 = 1'b0;
    bus.id_rs2 = 3'd0; bus.id_use_rs2 = 1'b0;
    bus.id_rd  = 3'd0; bus.id_regwrite = 1'b0;
    bus.id_memread = 1'b0; bus.branch_taken = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    got = {bus.stall, bus.forwardA, bus.forwardB, bus.flush};
    n_tests++;
    if (got !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_state: st/fa/fb/fl got %b expected %b", got, 6'b0);
    end
    reset = 1'b0;
  endtask

  task automatic test_fwd_ex();
    row_t rows[$];
    logic [5:0] got, exp;
    rows.push_back(nop());
    rows.push_back(nop());
    rows.push_back(mk(0,0, 0,0, 1,1,0,0, 0,2'b00,2'b00,0)); // ADD r1
    rows.push_back(mk(1,1, 2,1, 4,1,0,0, 0,2'b10,2'b00,0)); // SUB r4 <- r1,r2
    rows.push_back(mk(4,1, 1,1, 0,0,0,0, 0,2'b10,2'b01,0)); // use r4 (EX), r1 (MEM)
    rows.push_back(nop());
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      exp = sb.pop_front();
      got = {obs_stall, bus.forwardA, bus.forwardB, bus.flush};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL fwd_ex row %0d: st/fa/fb/fl got %b expected %b", i, got, exp);
      end
    end
  endtask

  task automatic test_fwd_mem();
    row_t rows[$];
    logic [5:0] got, exp;
    rows.push_back(nop());
    rows.push_back(nop());
    rows.push_back(mk(0,0, 0,0, 2,1,0,0, 0,2'b00,2'b00,0)); // ADD r2
    rows.push_back(nop());
    rows.push_back(mk(5,1, 2,1, 6,1,0,0, 0,2'b00,2'b01,0)); // rs2=2 from WB
    rows.push_back(mk(0,0, 0,0, 2,1,0,0, 0,2'b00,2'b00,0)); // ADD r2
    rows.push_back(mk(0,0, 0,0, 2,1,0,0, 0,2'b00,2'b00,0)); // ADD r2
    rows.push_back(mk(6,1, 2,1, 0,0,0,0, 0,2'b00,2'b10,0)); // newer r2 wins
    rows.push_back(nop());
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      exp = sb.pop_front();
      got = {obs_stall, bus.forwardA, bus.forwardB, bus.flush};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL fwd_mem row %0d: st/fa/fb/fl got %b expected %b", i, got, exp);
      end
    end
  endtask

  task automatic test_load_use();
    row_t rows[$];
    logic [5:0] got, exp;
    rows.push_back(nop());
    rows.push_back(nop());
    rows.push_back(mk(0,0, 0,0, 3,1,1,0, 0,2'b00,2'b00,0)); // LOAD r3
    rows.push_back(mk(3,1, 0,1, 5,1,0,0, 1,2'b00,2'b00,0)); // stall, bubble
    rows.push_back(mk(3,1, 0,1, 5,1,0,0, 0,2'b01,2'b00,0)); // replay, WB fwd
    rows.push_back(nop());
    rows.push_back(mk(0,0, 0,0, 3,1,1,0, 0,2'b00,2'b00,0)); // LOAD r3
    rows.push_back(mk(3,0, 4,1, 5,1,0,0, 0,2'b00,2'b00,0)); // rs1 unused: no stall
    rows.push_back(mk(0,0, 0,0, 3,1,1,0, 0,2'b00,2'b00,0)); // LOAD r3
    rows.push_back(mk(5,1, 3,1, 0,0,0,0, 1,2'b00,2'b00,0)); // rs2 hazard
    rows.push_back(mk(5,1, 3,1, 0,0,0,0, 0,2'b00,2'b01,0)); // replay
    rows.push_back(nop());
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      exp = sb.pop_front();
      got = {obs_stall, bus.forwardA, bus.forwardB, bus.flush};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL load_use row %0d: st/fa/fb/fl got %b expected %b", i, got, exp);
      end
    end
  endtask

  task automatic test_r0();
    row_t rows[$];
    logic [5:0] got, exp;
    rows.push_back(nop());
    rows.push_back(nop());
    rows.push_back(mk(0,0, 0,0, 0,1,0,0, 0,2'b00,2'b00,0)); // ADD r0
    rows.push_back(mk(0,1, 0,1, 0,1,1,0, 0,2'b00,2'b00,0)); // LOAD r0 reading r0
    rows.push_back(mk(0,1, 0,1, 0,0,0,0, 0,2'b00,2'b00,0)); // no stall on r0
    rows.push_back(nop());
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      exp = sb.pop_front();
      got = {obs_stall, bus.forwardA, bus.forwardB, bus.flush};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL r0 row %0d: st/fa/fb/fl got %b expected %b", i, got, exp);
      end
    end
  endtask

  task automatic test_flush();
    row_t rows[$];
    logic [5:0] got, exp;
    rows.push_back(nop());
    rows.push_back(nop());
    rows.push_back(mk(0,0, 0,0, 3,1,1,1, 0,2'b00,2'b00,1)); // LOAD r3 + branch
    rows.push_back(mk(3,1, 0,0, 5,1,0,1, 0,2'b00,2'b00,1)); // hazard masked, 2nd br
    rows.push_back(mk(3,1, 0,0, 5,1,0,0, 0,2'b00,2'b00,0)); // last flush cycle
    rows.push_back(nop());
    rows.push_back(mk(0,0, 0,0, 3,1,1,0, 0,2'b00,2'b00,0)); // LOAD r3
    rows.push_back(mk(3,1, 0,0, 5,1,0,1, 1,2'b00,2'b00,1)); // stall + branch
    rows.push_back(mk(3,1, 0,0, 5,1,0,0, 0,2'b00,2'b00,1));
    rows.push_back(nop());
    rows.push_back(nop());
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      exp = sb.pop_front();
      got = {obs_stall, bus.forwardA, bus.forwardB, bus.flush};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL flush row %0d: st/fa/fb/fl got %b expected %b", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    row_t rows[$];
    logic [5:0] got, exp;
    rows.push_back(nop());
    rows.push_back(nop());
    rows.push_back(mk(0,0, 0,0, 1,1,0,0, 0,2'b00,2'b00,0)); // ADD r1
    rows.push_back(mk(1,1, 0,0, 0,0,0,1, 0,2'b10,2'b00,1)); // use r1 + branch
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      exp = sb.pop_front();
      got = {obs_stall, bus.forwardA, bus.forwardB, bus.flush};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL mid_flush_pre row %0d: st/fa/fb/fl got %b expected %b", i, got, exp);
      end
    end
    // Asynchronous reset in the first flush cycle, checked before any edge.
    bus.branch_taken = 1'b0;
    reset = 1'b1;
    #1;
    got = {bus.stall, bus.forwardA, bus.forwardB, bus.flush};
    n_tests++;
    if (got !== 6'b0) begin
      n_fail++;
      $display("FAIL mid_flush_reset: st/fa/fb/fl got %b expected %b", got, 6'b0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    rows.delete();
    rows.push_back(mk(0,0, 0,0, 1,1,0,0, 0,2'b00,2'b00,0)); // ADD r1
    rows.push_back(mk(1,1, 1,1, 0,0,0,0, 0,2'b10,2'b10,0)); // use r1 twice
    rows.push_back(nop());
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      exp = sb.pop_front();
      got = {obs_stall, bus.forwardA, bus.forwardB, bus.flush};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL mid_flush_post row %0d: st/fa/fb/fl got %b expected %b", i, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fwd_ex();
    test_fwd_mem();
    test_load_use();
    test_r0();
    test_flush();
    test_reset_mid_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_hazard_forward_unit
